// File: rtl/hc_pkg.sv
// ---------------------------------------------------------------------------
// hc_pkg
// Shared definitions for the hc_core stream combiner:
//   HC_WORD_W     - width of keystream and data words
//   ctrl_state_e  - keystream controller FSM states
// ---------------------------------------------------------------------------
package hc_pkg;

    localparam int HC_WORD_W = 32;

    typedef enum logic [1:0] {
        CTRL_IDLE      = 2'd0,
        CTRL_WAIT_DROP = 2'd1,
        CTRL_WAIT_WORD = 2'd2,
        CTRL_DRAIN     = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/hc_ks_fifo.sv
// ---------------------------------------------------------------------------
// hc_ks_fifo
// Synchronous keystream prefetch FIFO.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   flush_i        - empty the FIFO (overrides push/pop in the same cycle)
//   push_i         - write push_data_i; honoured when not full, or when full
//                    and a pop happens in the same cycle
//   push_data_i    - word to write
//   pop_i          - discard the head word; ignored when empty
//   pop_data_o     - current head word (valid when empty_o = 0)
//   full_o/empty_o - occupancy flags
// ---------------------------------------------------------------------------
module hc_ks_fifo
    import hc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [HC_WORD_W-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [HC_WORD_W-1:0] pop_data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [HC_WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    // One extra bit so that full and empty are distinguishable.
    logic [AW:0]          count_q, count_d;
    logic                 do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DEPTH_CNT);
    assign pop_data_o = mem_q[rd_ptr_q];

    // When full, the slot being popped this cycle is the one written, so
    // a simultaneous push is safe.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/hc_stream_xor.sv
// ---------------------------------------------------------------------------
// hc_stream_xor
// Sequences hc_core (init/next), prefetches keystream words into a small
// FIFO and XORs them one-for-one onto a 32-bit data stream.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   start, abort          - begin a message / abandon it (abort wins)
//   core_init, core_next  - one-cycle control pulses to hc_core
//   core_result(_valid)   - keystream word from hc_core
//   din, din_last,
//   din_valid, din_ready  - input stream
//   dout, dout_last,
//   dout_valid, dout_ready- output stream, one cycle after acceptance
//   busy                  - controller not idle
//   word_count            - output words since the last start
// Handshake: a word moves on a channel in every cycle where its valid and
// ready are both high at the rising clock edge; valid never waits on ready.
// ---------------------------------------------------------------------------
module hc_stream_xor
    import hc_pkg::*;
#(
    parameter int KS_DEPTH = 4,
    parameter int KS_AW    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 core_init,
    output logic                 core_next,
    input  logic [HC_WORD_W-1:0] core_result,
    input  logic                 core_result_valid,
    input  logic [HC_WORD_W-1:0] din,
    input  logic                 din_last,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [HC_WORD_W-1:0] dout,
    output logic                 dout_last,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic [31:0]          word_count
);

    ctrl_state_e          state_q;
    logic                 core_init_q, core_next_q;
    logic [HC_WORD_W-1:0] dout_q, dout_d;
    logic                 dout_last_q, dout_last_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [31:0]          word_count_q, word_count_d;

    logic                 ks_push, ks_pop, ks_flush, ks_full, ks_empty;
    logic [HC_WORD_W-1:0] ks_head;
    logic                 streaming, start_go, accept, accept_last, out_fire;

    hc_ks_fifo #(
        .DEPTH (KS_DEPTH),
        .AW    (KS_AW)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (ks_flush),
        .push_i      (ks_push),
        .push_data_i (core_result),
        .pop_i       (ks_pop),
        .pop_data_o  (ks_head),
        .full_o      (ks_full),
        .empty_o     (ks_empty)
    );

    assign streaming   = (state_q == CTRL_WAIT_DROP) || (state_q == CTRL_WAIT_WORD);
    assign start_go    = start && !abort && (state_q == CTRL_IDLE);
    assign din_ready   = streaming && !ks_empty && (!dout_valid_q || dout_ready);
    // A word handed over in the abort cycle is dropped along with the message.
    assign accept      = din_valid && din_ready && !abort;
    assign accept_last = accept && din_last;
    assign out_fire    = dout_valid_q && dout_ready;

    // Once the last data word is taken no further keystream is requested.
    assign ks_push  = (state_q == CTRL_WAIT_WORD) && core_result_valid && !ks_full &&
                      !abort && !accept_last;
    assign ks_pop   = accept;
    assign ks_flush = abort || start_go;

    // Controller FSM. WAIT_DROP covers the cycle in which core_result_valid
    // may still show the word already consumed, before the core reacts to
    // the init/next pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CTRL_IDLE;
            core_init_q <= 1'b0;
            core_next_q <= 1'b0;
        end else begin
            core_init_q <= 1'b0;
            core_next_q <= 1'b0;
            if (abort) begin
                state_q <= CTRL_IDLE;
            end else begin
                case (state_q)
                    CTRL_IDLE: begin
                        if (start) begin
                            core_init_q <= 1'b1;
                            state_q     <= CTRL_WAIT_DROP;
                        end
                    end
                    CTRL_WAIT_DROP: begin
                        state_q <= accept_last ? CTRL_DRAIN : CTRL_WAIT_WORD;
                    end
                    CTRL_WAIT_WORD: begin
                        if (accept_last) begin
                            state_q <= CTRL_DRAIN;
                        end else if (ks_push) begin
                            core_next_q <= 1'b1;
                            state_q     <= CTRL_WAIT_DROP;
                        end
                    end
                    CTRL_DRAIN: begin
                        if (out_fire && dout_last_q) state_q <= CTRL_IDLE;
                    end
                    default: state_q <= CTRL_IDLE;
                endcase
            end
        end
    end

    // Output register: one-cycle latency, refilled in the same cycle it drains.
    always_comb begin
        dout_d       = dout_q;
        dout_last_d  = dout_last_q;
        dout_valid_d = dout_valid_q;
        word_count_d = word_count_q;
        if (abort) begin
            dout_valid_d = 1'b0;
        end else begin
            if (accept) begin
                dout_d       = din ^ ks_head;
                dout_last_d  = din_last;
                dout_valid_d = 1'b1;
            end else if (out_fire) begin
                dout_valid_d = 1'b0;
            end
            if (start_go)      word_count_d = '0;
            else if (out_fire) word_count_d = word_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q       <= '0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            word_count_q <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_last_q  <= dout_last_d;
            dout_valid_q <= dout_valid_d;
            word_count_q <= word_count_d;
        end
    end

    assign core_init  = core_init_q;
    assign core_next  = core_next_q;
    assign dout       = dout_q;
    assign dout_last  = dout_last_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q != CTRL_IDLE);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_hc_stream_xor.sv
module tb_hc_stream_xor;
  import hc_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk, reset_n;
  logic        start, abort;
  logic        core_init, core_next;
  logic [31:0] core_result;
  logic        core_result_valid;
  logic [31:0] din;
  logic        din_last, din_valid, din_ready;
  logic [31:0] dout;
  logic        dout_last, dout_valid, dout_ready;
  logic        busy;
  logic [31:0] word_count;

  // standalone FIFO for same-cycle push/pop corner cases
  logic        f_flush, f_push, f_pop, f_full, f_empty;
  logic [31:0] f_wdata, f_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  hc_stream_xor #(.KS_DEPTH(4), .KS_AW(2)) u_dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .abort             (abort),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_result       (core_result),
    .core_result_valid (core_result_valid),
    .din               (din),
    .din_last          (din_last),
    .din_valid         (din_valid),
    .din_ready         (din_ready),
    .dout              (dout),
    .dout_last         (dout_last),
    .dout_valid        (dout_valid),
    .dout_ready        (dout_ready),
    .busy              (busy),
    .word_count        (word_count)
  );

  hc_ks_fifo #(.DEPTH(4), .AW(2)) u_fifo_ut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (f_flush),
    .push_i      (f_push),
    .push_data_i (f_wdata),
    .pop_i       (f_pop),
    .pop_data_o  (f_rdata),
    .full_o      (f_full),
    .empty_o     (f_empty)
  );

  // ---------------- core model ----------------
  // nth word after init is 0x1000_0000 + n; valid drops on the edge that
  // samples init/next and rises again one cycle later.
  logic [31:0] core_n;
  logic        core_armed;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_n            <= 32'd0;
      core_armed        <= 1'b0;
      core_result_valid <= 1'b0;
    end else if (core_init) begin
      core_n            <= 32'd0;
      core_armed        <= 1'b1;
      core_result_valid <= 1'b0;
    end else if (core_next) begin
      core_n            <= core_n + 32'd1;
      core_result_valid <= 1'b0;
    end else if (core_armed && !core_result_valid) begin
      core_result_valid <= 1'b1;
    end
  end
  assign core_result = 32'h1000_0000 + core_n;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [32:0] exp_q[$];   // {last, data}
  int          out_cyc[$];
  int          cyc = 0;
  int          out_cnt = 0;
  int          init_cnt = 0;
  int          next_cnt = 0;
  int          proto_viol = 0;
  logic        prev_pulse = 1'b0;
  logic [32:0] mon_e;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic expect_word(input logic last, input logic [31:0] data);
    exp_q.push_back({last, data});
  endtask

  // monitor sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (core_init) init_cnt++;
        if (core_next) next_cnt++;
        if ((core_init && core_next) || ((core_init || core_next) && prev_pulse)) proto_viol++;
        prev_pulse = core_init || core_next;
        if (abort) begin
          exp_q.delete();
        end else if (dout_valid && dout_ready) begin
          out_cnt++;
          out_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check_eq("dout_extra", 32'(exp_q.size()), 32'd1);
          end else begin
            mon_e = exp_q.pop_front();
            check_eq("dout", dout, mon_e[31:0]);
            check_eq("dout_last", 32'(dout_last), 32'(mon_e[32]));
          end
        end
      end else begin
        prev_pulse = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(input int first, input int n, input logic [31:0] base, input bit last);
    for (int i = 0; i < n; i++) begin
      int waited;
      waited = 0;
      din       = base | 32'(first + i);
      din_last  = last && (i == n - 1);
      din_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (din_ready) begin
          tick();
          break;
        end
        waited++;
        if (waited > 300) begin
          check_eq("din_accept_timeout", 32'(waited), 32'd0);
          break;
        end
      end
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_outs(input int target, input int budget);
    int k;
    k = 0;
    while (out_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check_eq("out_timeout", 32'(out_cnt >= target), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_core_init"},  32'(core_init), 32'd0);
    check_eq({tag, "_core_next"},  32'(core_next), 32'd0);
    check_eq({tag, "_din_ready"},  32'(din_ready), 32'd0);
    check_eq({tag, "_dout"},       dout, 32'd0);
    check_eq({tag, "_dout_last"},  32'(dout_last), 32'd0);
    check_eq({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check_eq({tag, "_busy"},       32'(busy), 32'd0);
    check_eq({tag, "_word_count"}, word_count, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  int base_init, base_next, base_out;

  initial begin
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0;
    din = 32'd0; din_last = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    f_flush = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_wdata = 32'd0;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // ---- FIFO: push+pop when exactly full, then when exactly empty ----
    for (int i = 0; i < 4; i++) begin
      f_push = 1'b1; f_wdata = 32'h0000_00C0 + 32'(i);
      tick();
    end
    f_push = 1'b0;
    check_eq("ff_full", 32'(f_full), 32'd1);
    check_eq("ff_count_full", 32'(u_fifo_ut.count_q), 32'd4);
    f_push = 1'b1; f_pop = 1'b1; f_wdata = 32'h0000_00C4;
    #1;
    check_eq("ff_head_full", f_rdata, 32'h0000_00C0);
    tick();
    f_push = 1'b0;
    check_eq("ff_count_after_pp", 32'(u_fifo_ut.count_q), 32'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("ff_order", f_rdata, 32'h0000_00C1 + 32'(i));
      tick();
    end
    f_pop = 1'b0;
    check_eq("ff_empty", 32'(f_empty), 32'd1);
    f_push = 1'b1; f_pop = 1'b1; f_wdata = 32'h0000_00D0;
    tick();
    f_push = 1'b0; f_pop = 1'b0;
    check_eq("ff_count_empty_pp", 32'(u_fifo_ut.count_q), 32'd1);
    check_eq("ff_head_empty_pp", f_rdata, 32'h0000_00D0);
    f_pop = 1'b1;
    tick();
    f_pop = 1'b0;
    check_eq("ff_empty_end", 32'(f_empty), 32'd1);

    // ---- T1: basic 3-word message ----
    din_valid = 1'b1; din = 32'h0000_DEAD;
    tick();
    check_eq("idle_din_ready", 32'(din_ready), 32'd0);
    din_valid = 1'b0;
    base_init = init_cnt;
    start_msg();
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_init_pulse", 32'(core_init), 32'd1);
    tick();
    check_eq("t1_init_drop", 32'(core_init), 32'd0);
    expect_word(1'b0, 32'h1000_0000);
    expect_word(1'b0, 32'h1000_0000);
    expect_word(1'b1, 32'h1000_0000);
    send_words(0, 3, 32'h0, 1'b1);
    wait_idle(50);
    check_eq("t1_word_count", word_count, 32'd3);
    check_eq("t1_init_count", 32'(init_cnt - base_init), 32'd1);

    // ---- T2: back-pressure fills the FIFO, release gives a burst ----
    dout_ready = 1'b0;
    start_msg();
    base_next = next_cnt;
    for (int i = 0; i < 8; i++) expect_word(i == 7, 32'hB5A5_0000);
    fork
      send_words(0, 8, 32'hA5A5_0000, 1'b1);
      begin
        repeat (40) tick();
        check_eq("t2_next_at_full", 32'(next_cnt - base_next), 32'd5);
        check_eq("t2_fifo_count", 32'(u_dut.u_fifo.count_q), 32'd4);
        check_eq("t2_din_blocked", 32'(din_ready), 32'd0);
        repeat (20) tick();
        check_eq("t2_next_held", 32'(next_cnt - base_next), 32'd5);
        out_cyc.delete();
        dout_ready = 1'b1;
      end
    join
    wait_idle(100);
    check_eq("t2_outs", 32'(out_cyc.size()), 32'd8);
    if (out_cyc.size() >= 5) check_eq("t2_burst", 32'(out_cyc[4] - out_cyc[0]), 32'd4);
    check_eq("t2_next_resumed", 32'(next_cnt - base_next > 5), 32'd1);
    check_eq("t2_word_count", word_count, 32'd8);

    // ---- T3: abort after 2 words, abort beats start, re-start ----
    start_msg();
    base_out = out_cnt;
    expect_word(1'b0, 32'h1000_0000);
    expect_word(1'b0, 32'h1000_0000);
    send_words(0, 2, 32'h0, 1'b0);
    wait_outs(base_out + 2, 50);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t3_busy", 32'(busy), 32'd0);
    check_eq("t3_dout_valid", 32'(dout_valid), 32'd0);
    check_eq("t3_word_count", word_count, 32'd2);
    base_init = init_cnt;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check_eq("t3_abort_wins_busy", 32'(busy), 32'd0);
    check_eq("t3_abort_wins_init", 32'(init_cnt - base_init), 32'd0);
    start_msg();
    expect_word(1'b1, 32'h1000_0055);
    send_words(0, 1, 32'h0000_0055, 1'b1);
    wait_idle(50);
    check_eq("t3_restart_count", word_count, 32'd1);

    // ---- T4: start while busy is ignored ----
    start_msg();
    expect_word(1'b0, 32'h1000_0000);
    send_words(0, 1, 32'h0, 1'b0);
    base_init = init_cnt;
    start_msg();
    tick();
    check_eq("t4_no_init", 32'(init_cnt - base_init), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd1);
    expect_word(1'b0, 32'h1000_0000);
    expect_word(1'b1, 32'h1000_0000);
    send_words(1, 2, 32'h0, 1'b1);
    wait_idle(50);
    check_eq("t4_word_count", word_count, 32'd3);

    // ---- T5: asynchronous reset during WAIT_WORD with dout_valid high ----
    dout_ready = 1'b0;
    start_msg();
    send_words(0, 1, 32'h0, 1'b0);
    repeat (30) tick();
    check_eq("t5_pre_state", 32'(u_dut.state_q), 32'(CTRL_WAIT_WORD));
    check_eq("t5_pre_dout_valid", 32'(dout_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("t5_reset");
    repeat (2) tick();
    reset_n = 1'b1;
    dout_ready = 1'b1;
    base_init = init_cnt;
    base_next = next_cnt;
    repeat (20) tick();
    check_eq("t5_no_init", 32'(init_cnt - base_init), 32'd0);
    check_eq("t5_no_next", 32'(next_cnt - base_next), 32'd0);
    check_eq("t5_idle", 32'(busy), 32'd0);

    // ---- wrap-up ----
    check_eq("proto_pulses", 32'(proto_viol), 32'd0);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hc_stream_xor.md
Name: hc_stream_xor

Overview:
- Keystream consumer and data combiner for hc_core.
- Drives the core's init/next controls and prefetches 32-bit keystream words into a small FIFO.
- XORs each keystream word with one 32-bit word of an incoming data stream under valid/ready handshakes. Encrypt and decrypt are the same operation.
- Sits between the bus/DMA data path and hc_core. Key and IV go straight to the core; this block only sequences it.

Parameters:
- KS_DEPTH, 4, keystream prefetch FIFO depth in words; power of two, minimum 2.
- KS_AW, 2, FIFO address width; must equal log2(KS_DEPTH).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begin a new message (re-init the core, flush the FIFO)
- abort  input  1  pulse; stop the current message and return to IDLE
- core_init  output  1  one-cycle pulse to hc_core init
- core_next  output  1  one-cycle pulse to hc_core next
- core_result  input  32  keystream word from hc_core
- core_result_valid  input  1  keystream word valid from hc_core
- din  input  32  plaintext/ciphertext word
- din_last  input  1  marks the final word of the message
- din_valid  input  1  input word valid
- din_ready  output  1  input word accepted when valid and ready are both high
- dout  output  32  din XOR keystream
- dout_last  output  1  copy of din_last for this word
- dout_valid  output  1  output word valid
- dout_ready  input  1  downstream ready
- busy  output  1  high in any state other than IDLE
- word_count  output  32  words output since the last start; wraps at 2^32

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; word_count 0.
- Core contract:
  - core_result_valid falls the cycle after core_init or core_next is sampled.
  - It rises when a fresh word is available and stays high until the next core_next.
- Keystream FSM:
  - IDLE: on start, pulse core_init, flush the FIFO, clear word_count, go to WAIT_DROP.
  - WAIT_DROP: one cycle; ignore core_result_valid; go to WAIT_WORD.
  - WAIT_WORD: when core_result_valid=1 and the FIFO is not full, push core_result, pulse core_next, go to WAIT_DROP. If the FIFO is full, hold with no next pulse.
  - DRAIN: entered when a din_last word is accepted. Stop requesting words. When dout_valid and dout_ready fire with dout_last=1, go to IDLE.
- Data path:
  - din_ready = (state is WAIT_WORD or WAIT_DROP) AND FIFO not empty AND (dout_valid=0 OR dout_ready=1).
  - On accept: dout <= din ^ FIFO head, dout_last <= din_last, dout_valid <= 1; pop the FIFO.
  - Latency is exactly 1 cycle from accept to dout_valid.
  - Full throughput of 1 word per cycle while the FIFO is non-empty.
  - dout_valid clears on dout_ready unless a new word is accepted in the same cycle.
  - word_count increments on each dout handshake.
- Simultaneous push and pop in one cycle are both honoured. Full/empty are computed from a KS_AW+1-bit occupancy count.
- start outside IDLE is ignored; start together with abort means abort wins.
- abort in any state:
  - Next state IDLE; dout_valid cleared; FIFO flushed; no core pulse issued.
  - word_count holds its value.
- Keystream words prefetched beyond the last data word are discarded at the next start.
- din_valid while in IDLE or DRAIN: din_ready=0, so the word is not accepted.
- Asynchronous reset mid-message returns all state to reset values immediately.
- Only one of core_init and core_next is ever high in a given cycle. Neither is ever high for two consecutive cycles.

Decomposition:
- Package hc_pkg: FSM state encodings (CTRL_IDLE, CTRL_WAIT_DROP, CTRL_WAIT_WORD, CTRL_DRAIN) and the 32-bit word width constant.
- One sub-module, hc_ks_fifo: synchronous FIFO, width 32, depth KS_DEPTH, with push, pop, flush, full and empty.

Test Plan:
- Bench core model returns 0x1000_0000+n for the nth word after init (n from 0). Run start, then 3 words din=0x0,0x1,0x2 with the last flagged. Expect dout=0x10000000,0x10000000,0x10000000; dout_last only on the third; word_count=3; IDLE afterwards.
- dout_ready held low with din_valid high. Expect the FIFO to fill to KS_DEPTH, then no further core_next pulses. Release dout_ready: one word per cycle, and core_next resumes.
- abort mid-message after 2 words. Expect busy=0 next cycle, dout_valid=0, word_count=2. Then start: first dout = din ^ 0x10000000, proving the flush and re-init.
- start while busy. Expect no core_init pulse and the stream to continue unaffected.
- Push and pop in the same cycle with the FIFO exactly full, and again with it exactly empty. Expect occupancy correct, no lost or duplicated keystream word, word order preserved.
- reset_n asserted during WAIT_WORD with dout_valid=1. Expect every output 0 immediately, and after release no core pulses until start.
